// File: rtl/countdown_timer.sv
// countdown_timer: programmable N-bit down-counting timer.
// Loads a start value, decrements once per en_tick strobe while running,
// and flags expiry with a one-cycle done_tick. Supports one-shot and
// auto-reload operation. Priority on every edge: stop > start > en_tick/auto_reload.
module countdown_timer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  input  logic         en_tick,
  input  logic         auto_reload,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] q,
  output logic         busy,
  output logic         min_tick,
  output logic         done_tick
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       state;
  state_t       state_nxt;
  logic [N-1:0] q_nxt;
  logic [N-1:0] reload_reg;
  logic [N-1:0] reload_nxt;

  // Next-state, next-count and reload-value selection
  always_comb begin
    state_nxt  = state;
    q_nxt      = q;
    reload_nxt = reload_reg;
    unique case (state)
      IDLE: begin
        // stop outranks start, so a simultaneous start is dropped
        if (start && !stop) begin
          reload_nxt = load_val;
          q_nxt      = load_val;
          state_nxt  = (load_val != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (start) begin
          reload_nxt = load_val;
          q_nxt      = load_val;
          state_nxt  = (load_val != '0) ? RUN : DONE;
        end else if (en_tick) begin
          // q is never 0 in RUN, so the 1 -> 0 step is the expiry point
          if (q == ONE) begin
            q_nxt     = '0;
            state_nxt = DONE;
          end else begin
            q_nxt = q - ONE;
          end
        end
      end
      DONE: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (start) begin
          reload_nxt = load_val;
          q_nxt      = load_val;
          state_nxt  = (load_val != '0) ? RUN : DONE;
        end else if (auto_reload && (reload_reg != '0)) begin
          q_nxt     = reload_reg;
          state_nxt = RUN;
        end else begin
          q_nxt     = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        q_nxt     = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // State, count and registered Moore outputs (busy/done_tick follow the next state)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      q          <= '0;
      reload_reg <= '0;
      busy       <= 1'b0;
      done_tick  <= 1'b0;
    end else begin
      state      <= state_nxt;
      q          <= q_nxt;
      reload_reg <= reload_nxt;
      busy       <= (state_nxt != IDLE);
      done_tick  <= (state_nxt == DONE);
    end
  end

  assign min_tick = (q == '0);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (N=8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_countdown_timer;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         stop;
  logic         en_tick;
  logic         auto_reload;
  logic [N-1:0] load_val;
  logic [N-1:0] q;
  logic         busy;
  logic         min_tick;
  logic         done_tick;

  int checks = 0;
  int errors = 0;

  // Observed vector: {q, busy, done_tick, min_tick}
  logic [N+2:0] obs;
  assign obs = {q, busy, done_tick, min_tick};

  countdown_timer #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .en_tick     (en_tick),
    .auto_reload (auto_reload),
    .load_val    (load_val),
    .q           (q),
    .busy        (busy),
    .min_tick    (min_tick),
    .done_tick   (done_tick)
  );

  always #5 clk = ~clk;

  // Expected {q, busy, done_tick, min_tick}; min_tick derived from the expected count
  function automatic logic [N+2:0] pk(input int qv, input bit b, input bit d);
    logic [N-1:0] qq;
    qq = qv[N-1:0];
    return {qq, b, d, (qq == '0)};
  endfunction

  task automatic test_reset;
    logic [N+2:0] e;
    reset = 1'b1; start = 1'b0; stop = 1'b0; en_tick = 1'b0;
    auto_reload = 1'b0; load_val = '0;
    #1;
    e = pk(0, 0, 0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_async: got %b expected %b", obs, e);
    end
    @(negedge clk);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_held: got %b expected %b", obs, e);
    end
    reset = 1'b0;
    en_tick = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_idle_ignores_tick: got %b expected %b", obs, e);
    end
    en_tick = 1'b0;
  endtask

  task automatic test_one_shot;
    logic [N+2:0] e;
    load_val = 8'd5; auto_reload = 1'b0; en_tick = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e = pk(5, 1, 0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL one_shot_load: got %b expected %b", obs, e);
    end
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      e = pk(5 - i, 1, (i == 5));
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL one_shot_step%0d: got %b expected %b", i, obs, e);
      end
    end
    @(negedge clk);
    e = pk(0, 0, 0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL one_shot_idle: got %b expected %b", obs, e);
    end
    en_tick = 1'b0;
  endtask

  task automatic test_auto_reload;
    logic [N+2:0] e;
    int qv;
    load_val = 8'd3; auto_reload = 1'b1; en_tick = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e = pk(3, 1, 0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reload_load: got %b expected %b", obs, e);
    end
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      qv = ((i % 4) == 0) ? 3 : 3 - (i % 4);
      e = pk(qv, 1, (qv == 0));
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reload_step%0d: got %b expected %b", i, obs, e);
      end
    end
    stop = 1'b1; auto_reload = 1'b0;
    @(negedge clk);
    stop = 1'b0; en_tick = 1'b0;
    e = pk(3, 0, 0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reload_stop: got %b expected %b", obs, e);
    end
  endtask

  task automatic test_slow_tick;
    logic [N+2:0] e;
    load_val = 8'd255; auto_reload = 1'b0; en_tick = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e = pk(255, 1, 0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL slow_load: got %b expected %b", obs, e);
    end
    for (int s = 1; s <= 255; s++) begin
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        e = pk(256 - s, 1, 0);
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL slow_hold_s%0d: got %b expected %b", s, obs, e);
        end
      end
      en_tick = 1'b1;
      @(negedge clk);
      en_tick = 1'b0;
      e = pk(255 - s, 1, (s == 255));
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL slow_strobe_s%0d: got %b expected %b", s, obs, e);
      end
    end
    @(negedge clk);
    e = pk(0, 0, 0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL slow_idle: got %b expected %b", obs, e);
    end
  endtask

  task automatic test_stop;
    logic [N+2:0] e;
    load_val = 8'd5; auto_reload = 1'b0; en_tick = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    e = pk(2, 1, 0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL stop_pre: got %b expected %b", obs, e);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    e = pk(2, 0, 0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL stop_abort: got %b expected %b", obs, e);
    end
    @(negedge clk);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL stop_no_done: got %b expected %b", obs, e);
    end
    load_val = 8'd9; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL stop_beats_start_idle: got %b expected %b", obs, e);
    end
    load_val = 8'd7; en_tick = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e = pk(7, 1, 0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL stop_run_load: got %b expected %b", obs, e);
    end
    load_val = 8'd20; start = 1'b1; stop = 1'b1; en_tick = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; en_tick = 1'b0;
    e = pk(7, 0, 0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL stop_beats_start_run: got %b expected %b", obs, e);
    end
  endtask

  task automatic test_zero_load;
    logic [N+2:0] e;
    for (int m = 0; m < 2; m++) begin
      auto_reload = (m == 1); load_val = '0; en_tick = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      e = pk(0, 1, 1);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL zero_done_ar%0d: got %b expected %b", m, obs, e);
      end
      @(negedge clk);
      e = pk(0, 0, 0);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL zero_idle_ar%0d: got %b expected %b", m, obs, e);
      end
      @(negedge clk);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL zero_stays_idle_ar%0d: got %b expected %b", m, obs, e);
      end
    end
    auto_reload = 1'b0; en_tick = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [N+2:0] e;
    load_val = 8'd1; auto_reload = 1'b0; en_tick = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e = pk(1, 1, 0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL b2b_load1: got %b expected %b", obs, e);
    end
    @(negedge clk);
    e = pk(0, 1, 1);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL b2b_done1: got %b expected %b", obs, e);
    end
    load_val = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e = pk(4, 1, 0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL b2b_restart_in_done: got %b expected %b", obs, e);
    end
    repeat (4) @(negedge clk);
    e = pk(0, 1, 1);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL b2b_done4: got %b expected %b", obs, e);
    end
    stop = 1'b1; auto_reload = 1'b1;
    @(negedge clk);
    stop = 1'b0; auto_reload = 1'b0; en_tick = 1'b0;
    e = pk(0, 0, 0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL b2b_stop_in_done: got %b expected %b", obs, e);
    end
  endtask

  task automatic test_async_reset;
    logic [N+2:0] e;
    load_val = 8'd50; auto_reload = 1'b0; en_tick = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    e = pk(40, 1, 0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL arst_pre: got %b expected %b", obs, e);
    end
    #2 reset = 1'b1;
    #1;
    e = pk(0, 0, 0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL arst_immediate: got %b expected %b", obs, e);
    end
    @(negedge clk);
    reset = 1'b0;
    load_val = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e = pk(3, 1, 0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL arst_restart_load: got %b expected %b", obs, e);
    end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      e = (i == 4) ? pk(0, 0, 0) : pk(3 - i, 1, (i == 3));
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL arst_restart_step%0d: got %b expected %b", i, obs, e);
      end
    end
    en_tick = 1'b0;
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_slow_tick();
    test_stop();
    test_zero_load();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
